// File: rtl/perf_scanner.sv
// Perf-bus scanner: walks FIRST_ADDR..LAST_ADDR, reads each counter and streams (addr, value) out.
// Optional ack timeout is built when PERF_SCAN_TIMEOUT_EN is defined.
module perf_scanner #(
  parameter logic [7:0]  FIRST_ADDR = 8'h00,
  parameter logic [7:0]  LAST_ADDR  = 8'hFF,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_continuous,
  output logic [7:0]  o_perf_addr,
  output logic        o_perf_stb,
  input  logic        i_perf_ack,
  input  logic [31:0] i_perf_data,
  input  logic        i_perf_stall,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [7:0]  o_addr,
  output logic [31:0] o_data,
  output logic        o_timeout,
  output logic        o_busy,
  output logic        o_done
);

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  if (FIRST_ADDR > LAST_ADDR || TIMEOUT == 0) begin : g_param_check
    $error("perf_scanner: FIRST_ADDR must not exceed LAST_ADDR and TIMEOUT must be nonzero");
  end

  // ADV inserts the idle bus cycle between an accepted entry and the next strobe;
  // FIN keeps o_busy high during the o_done pulse so a coincident start is ignored.
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_EMIT,
    S_ADV,
    S_FIN
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cur_q, cur_d;
  logic                stb_q, stb_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

`ifdef PERF_SCAN_TIMEOUT_EN
  localparam int unsigned CNT_W = 16;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tmo_q, tmo_d;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    stb_d   = stb_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef PERF_SCAN_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          cur_d   = FIRST_ADDR;
          stb_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (!i_perf_stall) begin
          stb_d   = 1'b0;
          state_d = S_WAIT;
`ifdef PERF_SCAN_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_WAIT: begin
        if (i_perf_ack) begin
          data_d  = i_perf_data;
          addr_d  = cur_q;
          valid_d = 1'b1;
          state_d = S_EMIT;
`ifdef PERF_SCAN_TIMEOUT_EN
          tmo_d   = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          data_d  = '1;
          addr_d  = cur_q;
          valid_d = 1'b1;
          tmo_d   = 1'b1;
          state_d = S_EMIT;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
`endif
        end
      end
      S_EMIT: begin
        if (i_ready) begin
          valid_d = 1'b0;
          if (cur_q != LAST_ADDR) begin
            cur_d   = cur_q + ADDR_W'(1);
            state_d = S_ADV;
          end else begin
            done_d = 1'b1;
            if (i_continuous) begin
              cur_d   = FIRST_ADDR;
              state_d = S_ADV;
            end else begin
              state_d = S_FIN;
            end
          end
        end
      end
      S_ADV: begin
        stb_d   = 1'b1;
        state_d = S_REQ;
      end
      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      stb_q   <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      stb_q   <= stb_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef PERF_SCAN_TIMEOUT_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
  assign o_timeout = tmo_q;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_perf_addr = cur_q;
  assign o_perf_stb  = stb_q;
  assign o_valid     = valid_q;
  assign o_addr      = addr_q;
  assign o_data      = data_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_perf_scanner.sv
// Randomized self-checking bench for perf_scanner with a perf-bus slave model and stream scoreboard.
module tb_perf_scanner;

  localparam logic [7:0]  FIRST = 8'h02;
  localparam logic [7:0]  LAST  = 8'h04;
  localparam int unsigned TMO   = 16;

  logic        i_clk, i_reset, i_start, i_continuous;
  logic [7:0]  o_perf_addr;
  logic        o_perf_stb, i_perf_ack, i_perf_stall;
  logic [31:0] i_perf_data;
  logic        o_valid, i_ready, o_timeout, o_busy, o_done;
  logic [7:0]  o_addr;
  logic [31:0] o_data;

  perf_scanner #(.FIRST_ADDR(FIRST), .LAST_ADDR(LAST), .TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_continuous(i_continuous),
    .o_perf_addr(o_perf_addr), .o_perf_stb(o_perf_stb), .i_perf_ack(i_perf_ack),
    .i_perf_data(i_perf_data), .i_perf_stall(i_perf_stall), .o_valid(o_valid),
    .i_ready(i_ready), .o_addr(o_addr), .o_data(o_data), .o_timeout(o_timeout),
    .o_busy(o_busy), .o_done(o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
    logic        t;
  } ent_t;

  int          n_pass, n_total;
  int          cyc, start_cyc, done_cyc, done_cnt, valid_seen;
  int          stb_cnt [256];
  logic [31:0] vals [256];
  bit          silent [256];
  bit          inject_ack;
  ent_t        got[$];
  ent_t        exp_q[$];
  logic        slv_acc;
  logic [7:0]  slv_addr;

  // Slave: acks one cycle after an accepted strobe; data is 0 when not acking
  always @(posedge i_clk) begin
    slv_acc  = o_perf_stb && !i_perf_stall;
    slv_addr = o_perf_addr;
    #1;
    if (inject_ack) begin
      i_perf_ack  = 1'b1;
      i_perf_data = 32'hDEAD_BEEF;
    end else if (slv_acc && !silent[slv_addr]) begin
      i_perf_ack  = 1'b1;
      i_perf_data = vals[slv_addr];
    end else begin
      i_perf_ack  = 1'b0;
      i_perf_data = 32'h0;
    end
  end

  // Stream / event monitor
  always @(posedge i_clk) begin
    ent_t e;
    if (i_start && !o_busy && !i_reset) start_cyc = cyc;
    if (o_valid && i_ready) begin
      e = {o_addr, o_data, o_timeout};
      got.push_back(e);
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (o_perf_stb) stb_cnt[o_perf_addr]++;
    if (o_valid) valid_seen++;
    cyc++;
  end

  // Reference: every sweep reads FIRST..LAST in order; silent slaves time out
  function automatic void model_scan(input int sweeps);
    exp_q.delete();
    for (int s = 0; s < sweeps; s++) begin
      for (int a = int'(FIRST); a <= int'(LAST); a++) begin
        ent_t e;
        e.a = 8'(a);
        if (silent[a]) begin
          e.d = 32'hFFFF_FFFF;
          e.t = 1'b1;
        end else begin
          e.d = vals[a];
          e.t = 1'b0;
        end
        exp_q.push_back(e);
      end
    end
  endfunction

  task automatic clear_log();
    got.delete();
    done_cnt   = 0;
    valid_seen = 0;
    start_cyc  = -1;
    done_cyc   = -1;
    for (int i = 0; i < 256; i++) stb_cnt[i] = 0;
  endtask

  task automatic start_pulse();
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic wait_idle(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge i_clk);
      if (done_cnt >= n && !o_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] obs [8];
    string       nm [8];
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    obs = '{32'(o_perf_stb), 32'(o_perf_addr), 32'(o_valid), 32'(o_addr),
            o_data, 32'(o_timeout), 32'(o_busy), 32'(o_done)};
    nm  = '{"stb", "perf_addr", "valid", "addr", "data", "timeout", "busy", "done"};
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (obs[i] !== 32'h0) $display("FAIL reset_%s got %h exp 0", nm[i], obs[i]);
      else n_pass++;
    end
    i_reset = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_sweep();
    bit ok;
    clear_log();
    start_pulse();
    wait_idle(1, 200, ok);
    model_scan(1);
    n_total++; if (!ok) $display("FAIL sweep_timeout busy=%b done_cnt=%0d", o_busy, done_cnt); else n_pass++;
    n_total++; if (got.size() != exp_q.size()) $display("FAIL sweep_len got %0d exp %0d", got.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) if (i < got.size()) begin
      n_total++;
      if (got[i] !== exp_q[i]) $display("FAIL sweep_entry%0d got %h exp %h", i, got[i], exp_q[i]); else n_pass++;
    end
    n_total++; if (done_cnt != 1) $display("FAIL sweep_done_cnt got %0d exp 1", done_cnt); else n_pass++;
    n_total++; if (done_cyc - start_cyc != 12) $display("FAIL sweep_latency got %0d exp 12", done_cyc - start_cyc); else n_pass++;
    n_total++; if (stb_cnt[2] + stb_cnt[3] + stb_cnt[4] != 3) $display("FAIL sweep_stb_cycles got %0d exp 3", stb_cnt[2] + stb_cnt[3] + stb_cnt[4]); else n_pass++;
    n_total++; if (o_busy !== 1'b0) $display("FAIL sweep_busy_after got %b exp 0", o_busy); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_log();
    start_pulse();
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (o_perf_stb && o_perf_addr == 8'd3) ok = 1'b1; else @(negedge i_clk);
    end
    i_ready = 1'b0;
    for (int i = 0; i < 10 && !o_valid; i++) @(negedge i_clk);
    for (int k = 0; k < 5; k++) begin
      n_total++;
      if ({o_valid, o_addr, o_data, o_perf_stb} !== {1'b1, 8'd3, 32'd30, 1'b0})
        $display("FAIL hold_cycle%0d got v=%b a=%0d d=%0d stb=%b exp v=1 a=3 d=30 stb=0", k, o_valid, o_addr, o_data, o_perf_stb);
      else n_pass++;
      @(negedge i_clk);
    end
    i_ready = 1'b1;
    wait_idle(1, 200, ok);
    model_scan(1);
    n_total++; if (!ok || got.size() != exp_q.size()) $display("FAIL hold_len got %0d exp %0d", got.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) if (i < got.size()) begin
      n_total++;
      if (got[i] !== exp_q[i]) $display("FAIL hold_entry%0d got %h exp %h", i, got[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_stall();
    bit ok;
    clear_log();
    @(negedge i_clk);
    i_start = 1'b1;
    i_perf_stall = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (3) @(negedge i_clk);
    i_perf_stall = 1'b0;
    wait_idle(1, 200, ok);
    model_scan(1);
    n_total++; if (stb_cnt[2] != 4) $display("FAIL stall_stb_hold got %0d exp 4", stb_cnt[2]); else n_pass++;
    n_total++; if (done_cyc - start_cyc != 15) $display("FAIL stall_latency got %0d exp 15", done_cyc - start_cyc); else n_pass++;
    n_total++; if (!ok || got.size() != exp_q.size()) $display("FAIL stall_len got %0d exp %0d", got.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) if (i < got.size()) begin
      n_total++;
      if (got[i] !== exp_q[i]) $display("FAIL stall_entry%0d got %h exp %h", i, got[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_start_on_done();
    clear_log();
    start_pulse();
    for (int i = 0; i < 100 && !o_done; i++) @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (20) @(negedge i_clk);
    n_total++; if (done_cnt != 1) $display("FAIL start_on_done_cnt got %0d exp 1", done_cnt); else n_pass++;
    n_total++; if (o_busy !== 1'b0) $display("FAIL start_on_done_busy got %b exp 0", o_busy); else n_pass++;
    n_total++; if (got.size() != 3) $display("FAIL start_on_done_len got %0d exp 3", got.size()); else n_pass++;
  endtask

  task automatic test_continuous();
    bit ok;
    clear_log();
    i_continuous = 1'b1;
    start_pulse();
    for (int i = 0; i < 100 && done_cnt < 1; i++) @(negedge i_clk);
    i_continuous = 1'b0;
    wait_idle(2, 200, ok);
    repeat (10) @(negedge i_clk);
    model_scan(2);
    n_total++; if (done_cnt != 2) $display("FAIL cont_done_cnt got %0d exp 2", done_cnt); else n_pass++;
    n_total++; if (!ok || got.size() != exp_q.size()) $display("FAIL cont_len got %0d exp %0d", got.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) if (i < got.size()) begin
      n_total++;
      if (got[i] !== exp_q[i]) $display("FAIL cont_entry%0d got %h exp %h", i, got[i], exp_q[i]); else n_pass++;
    end
    n_total++; if (o_busy !== 1'b0) $display("FAIL cont_busy_after got %b exp 0", o_busy); else n_pass++;
  endtask

`ifdef PERF_SCAN_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int first;
    clear_log();
    silent[3] = 1'b1;
    start_pulse();
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (o_perf_stb && o_perf_addr == 8'd3) ok = 1'b1; else @(negedge i_clk);
    end
    i_ready = 1'b0;
    first = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge i_clk);
      if (o_valid && first < 0) first = k;
    end
    inject_ack = 1'b1;
    @(negedge i_clk);
    inject_ack = 1'b0;
    repeat (2) @(negedge i_clk);
    n_total++; if (first != 17) $display("FAIL tmo_valid_cycle got %0d exp 17", first); else n_pass++;
    n_total++;
    if ({o_valid, o_addr, o_data, o_timeout} !== {1'b1, 8'd3, 32'hFFFF_FFFF, 1'b1})
      $display("FAIL tmo_entry_hold got v=%b a=%0d d=%h t=%b exp v=1 a=3 d=ffffffff t=1", o_valid, o_addr, o_data, o_timeout);
    else n_pass++;
    i_ready = 1'b1;
    wait_idle(1, 200, ok);
    model_scan(1);
    silent[3] = 1'b0;
    n_total++; if (!ok || got.size() != exp_q.size()) $display("FAIL tmo_len got %0d exp %0d", got.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) if (i < got.size()) begin
      n_total++;
      if (got[i] !== exp_q[i]) $display("FAIL tmo_entry%0d got %h exp %h", i, got[i], exp_q[i]); else n_pass++;
    end
  endtask
`endif

  task automatic test_reset_midscan();
    bit ok;
    clear_log();
    start_pulse();
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (o_perf_stb && o_perf_addr == 8'd3) ok = 1'b1; else @(negedge i_clk);
    end
    @(posedge i_clk);
    #2 i_reset = 1'b1;
    #1;
    n_total++;
    if ({o_perf_stb, o_perf_addr, o_valid, o_addr, o_data, o_timeout, o_busy, o_done} !== '0)
      $display("FAIL midreset_outputs got stb=%b pa=%h v=%b a=%h d=%h t=%b busy=%b done=%b exp all 0",
               o_perf_stb, o_perf_addr, o_valid, o_addr, o_data, o_timeout, o_busy, o_done);
    else n_pass++;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    clear_log();
    repeat (10) @(negedge i_clk);
    n_total++;
    if (valid_seen != 0 || done_cnt != 0 || o_busy !== 1'b0)
      $display("FAIL midreset_quiet got valid_cycles=%0d done=%0d busy=%b exp 0 0 0", valid_seen, done_cnt, o_busy);
    else n_pass++;
    start_pulse();
    wait_idle(1, 200, ok);
    model_scan(1);
    n_total++; if (done_cyc - start_cyc != 12) $display("FAIL midreset_latency got %0d exp 12", done_cyc - start_cyc); else n_pass++;
    n_total++; if (!ok || got.size() != exp_q.size()) $display("FAIL midreset_len got %0d exp %0d", got.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) if (i < got.size()) begin
      n_total++;
      if (got[i] !== exp_q[i]) $display("FAIL midreset_entry%0d got %h exp %h", i, got[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_random();
    int nsw;
    bit ok;
    for (int it = 0; it < 4; it++) begin
      for (int a = int'(FIRST); a <= int'(LAST); a++) vals[a] = $urandom;
      nsw = $urandom_range(1, 3);
      clear_log();
      i_continuous = (nsw > 1);
      start_pulse();
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        @(negedge i_clk);
        i_ready      = ($urandom_range(0, 1) == 1);
        i_perf_stall = ($urandom_range(0, 3) == 0);
        if (done_cnt >= nsw - 1) i_continuous = 1'b0;
        if (done_cnt >= nsw && !o_busy) begin
          ok = 1'b1;
          break;
        end
      end
      i_ready = 1'b1;
      i_perf_stall = 1'b0;
      i_continuous = 1'b0;
      model_scan(nsw);
      n_total++; if (done_cnt != nsw) $display("FAIL rand%0d_done_cnt got %0d exp %0d", it, done_cnt, nsw); else n_pass++;
      n_total++; if (!ok || got.size() != exp_q.size()) $display("FAIL rand%0d_len got %0d exp %0d", it, got.size(), exp_q.size()); else n_pass++;
      foreach (exp_q[i]) if (i < got.size()) begin
        n_total++;
        if (got[i] !== exp_q[i]) $display("FAIL rand%0d_entry%0d got %h exp %h", it, i, got[i], exp_q[i]); else n_pass++;
      end
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    cyc = 0;
    i_reset = 1'b1;
    i_start = 1'b0;
    i_continuous = 1'b0;
    i_ready = 1'b1;
    i_perf_stall = 1'b0;
    i_perf_ack = 1'b0;
    i_perf_data = 32'h0;
    inject_ack = 1'b0;
    for (int i = 0; i < 256; i++) begin
      vals[i]   = 32'(10 * i);
      silent[i] = 1'b0;
    end
    clear_log();
    test_reset();
    test_sweep();
    test_backpressure();
    test_stall();
    test_start_on_done();
    test_continuous();
`ifdef PERF_SCAN_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_midscan();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
